// File: rtl/spi_slave_core.sv
// SPI slave core: oversamples SCLK/SS_N/MOSI in the clk domain, supports all four
// CPOL/CPHA modes, and exchanges words through a 1-entry TX holding register and an RX valid/ready port.
module spi_slave_core #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  cpol_i,
   input  logic                  cpha_i,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic                  rx_ready_i,
   output logic                  rx_overrun_o,
   output logic                  tx_underrun_o,
   output logic                  busy_o,
   input  logic                  spi_sclk_i,
   input  logic                  spi_ss_n_i,
   input  logic                  spi_mosi_i,
   output logic                  spi_miso_o,
   output logic                  spi_miso_oe_o
);

   localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] sclkSync_q, ssSync_q, mosiSync_q, flush_q;
   logic                   sclkS, ssS, mosiS;

   state_t                 state_q, state_d;
   logic                   sclkPrev_q, sclkPrev_d, ssPrev_q, ssPrev_d;
   logic                   cpol_q, cpol_d, cpha_q, cpha_d;
   logic [DATA_WIDTH-1:0]  shiftTx_q, shiftTx_d, shiftRx_q, shiftRx_d;
   logic [CNT_W-1:0]       bitCnt_q, bitCnt_d;
   logic                   skipShift_q, skipShift_d;
   logic [DATA_WIDTH-1:0]  hold_q, hold_d;
   logic                   holdFull_q, holdFull_d;
   logic [DATA_WIDTH-1:0]  rxData_q, rxData_d;
   logic                   rxValid_q, rxValid_d, rxOverrun_q, rxOverrun_d;
   logic                   txUnderrun_q, txUnderrun_d;

   logic                   leadEdge, trailEdge, sampleEdge, shiftEdge, ssFall;
   logic                   doLoad, loadSkip;
   logic [DATA_WIDTH-1:0]  rxWord;

   // flush_q keeps the preset idle level of the ss_n chain from posing as a
   // real falling edge after reset, so a frame always needs a fresh ss_n fall.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sclkSync_q <= {SYNC_STAGES{cpol_i}};
         ssSync_q   <= '1;
         mosiSync_q <= '0;
         flush_q    <= '0;
      end else begin
         sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], spi_sclk_i};
         ssSync_q   <= {ssSync_q[SYNC_STAGES-2:0], spi_ss_n_i};
         mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], spi_mosi_i};
         flush_q    <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sclkS = sclkSync_q[SYNC_STAGES-1];
   assign ssS   = ssSync_q[SYNC_STAGES-1];
   assign mosiS = mosiSync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         sclkPrev_q   <= cpol_i;
         ssPrev_q     <= 1'b0;
         cpol_q       <= 1'b0;
         cpha_q       <= 1'b0;
         shiftTx_q    <= '0;
         shiftRx_q    <= '0;
         bitCnt_q     <= '0;
         skipShift_q  <= 1'b0;
         hold_q       <= '0;
         holdFull_q   <= 1'b0;
         rxData_q     <= '0;
         rxValid_q    <= 1'b0;
         rxOverrun_q  <= 1'b0;
         txUnderrun_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sclkPrev_q   <= sclkPrev_d;
         ssPrev_q     <= ssPrev_d;
         cpol_q       <= cpol_d;
         cpha_q       <= cpha_d;
         shiftTx_q    <= shiftTx_d;
         shiftRx_q    <= shiftRx_d;
         bitCnt_q     <= bitCnt_d;
         skipShift_q  <= skipShift_d;
         hold_q       <= hold_d;
         holdFull_q   <= holdFull_d;
         rxData_q     <= rxData_d;
         rxValid_q    <= rxValid_d;
         rxOverrun_q  <= rxOverrun_d;
         txUnderrun_q <= txUnderrun_d;
      end
   end

   assign leadEdge   = (sclkPrev_q == cpol_q) && (sclkS != cpol_q);
   assign trailEdge  = (sclkPrev_q != cpol_q) && (sclkS == cpol_q);
   assign sampleEdge = cpha_q ? trailEdge : leadEdge;
   assign shiftEdge  = cpha_q ? leadEdge : trailEdge;
   assign ssFall     = ssPrev_q && !ssS;
   assign rxWord     = {shiftRx_q[DATA_WIDTH-2:0], mosiS};

   always_comb begin
      state_d      = state_q;
      sclkPrev_d   = sclkS;
      ssPrev_d     = ssS & flush_q[SYNC_STAGES-1];
      cpol_d       = cpol_q;
      cpha_d       = cpha_q;
      shiftTx_d    = shiftTx_q;
      shiftRx_d    = shiftRx_q;
      bitCnt_d     = bitCnt_q;
      skipShift_d  = skipShift_q;
      hold_d       = hold_q;
      holdFull_d   = holdFull_q;
      rxData_d     = rxData_q;
      rxValid_d    = rxValid_q;
      rxOverrun_d  = rxOverrun_q;
      txUnderrun_d = 1'b0;
      doLoad       = 1'b0;
      loadSkip     = 1'b0;

      if (tx_valid_i && !holdFull_q) begin
         hold_d     = tx_data_i;
         holdFull_d = 1'b1;
      end
      if (rxValid_q && rx_ready_i) begin
         rxValid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (ssFall) begin
               state_d  = ACTIVE;
               cpol_d   = cpol_i;
               cpha_d   = cpha_i;
               bitCnt_d = '0;
               doLoad   = 1'b1;
               loadSkip = cpha_i;
            end
         end
         ACTIVE: begin
            // ss_n release wins over a coincident sample edge
            if (ssS) begin
               state_d     = IDLE;
               bitCnt_d    = '0;
               shiftRx_d   = '0;
               skipShift_d = 1'b0;
            end else if (sampleEdge) begin
               shiftRx_d = rxWord;
               if (bitCnt_q == LAST_BIT) begin
                  bitCnt_d = '0;
                  doLoad   = 1'b1;
                  loadSkip = 1'b1;
                  if (rxValid_q && !rx_ready_i) begin
                     rxOverrun_d = 1'b1;
                  end else begin
                     rxData_d  = rxWord;
                     rxValid_d = 1'b1;
                  end
               end else begin
                  bitCnt_d = bitCnt_q + CNT_W'(1);
               end
            end else if (shiftEdge) begin
               if (skipShift_q) begin
                  skipShift_d = 1'b0;
               end else begin
                  shiftTx_d = shiftTx_q << 1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Empty holding register at load time sends all ones and flags an underrun.
      if (doLoad) begin
         skipShift_d = loadSkip;
         if (holdFull_q) begin
            shiftTx_d  = hold_q;
            holdFull_d = 1'b0;
         end else begin
            shiftTx_d    = '1;
            txUnderrun_d = 1'b1;
         end
      end
   end

   assign tx_ready_o    = !holdFull_q;
   assign rx_data_o     = rxData_q;
   assign rx_valid_o    = rxValid_q;
   assign rx_overrun_o  = rxOverrun_q;
   assign tx_underrun_o = txUnderrun_q;
   assign busy_o        = (state_q == ACTIVE);
   assign spi_miso_oe_o = (state_q == ACTIVE);
   assign spi_miso_o    = (state_q == ACTIVE) ? shiftTx_q[DATA_WIDTH-1] : 1'b1;

endmodule
